seq_detector_param: RTL and testbench

Parametrised serial sequence detector, the generalised successor to our fixed 4-bit "1101" Mealy detector. It samples one bit per enabled clock and compares it against a PAT_W-bit pattern that is loadable at run time. It raises a Mealy match output in the same cycle as the completing bit, plus a registered copy. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits on the serial input path, downstream of the input synchroniser, and feeds status/LED logic.

---
 rtl/seq_detector_param.sv | 83 ++++++++
 tb/tb_seq_detector_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial sequence detector with a run-time loadable PAT_W-bit pattern, a Mealy match
// output, a registered match copy and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1101,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             p1,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_reg,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned     FillW   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_reg_q;
  logic [PAT_W-1:0] window;

  // Oldest retained bit lands in the MSB, matching the MSB-first pattern.
  assign window = {hist_q, p1};
  assign z      = reset & en & ~pat_load & (fill_q == FillMax) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (z && !overlap) begin
        // Non-overlapping: the matched bits must not seed the next match.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (z && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      z_reg_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      z_reg_q <= z;
    end
  end

  assign z_reg     = z_reg_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a bit-queue reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       p1 = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       z8, z_reg8, z2, z_reg2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .p1(p1), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .z(z8), .z_reg(z_reg8), .match_cnt(cnt8)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .p1(p1), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .z(z2), .z_reg(z_reg2), .match_cnt(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last three accepted bits (oldest first), the pattern, counts.
  bit         m_q[$];
  logic [3:0] m_pat;
  bit         m_zreg;
  int         m_cnt8, m_cnt2;
  bit         m_started = 1'b0;

  function automatic bit model_z();
    if (!(reset && en && !pat_load)) return 1'b0;
    if (m_q.size() < 3) return 1'b0;
    for (int i = 0; i < 3; i++) if (m_q[i] != m_pat[3-i]) return 1'b0;
    return p1 == m_pat[0];
  endfunction

  // Inputs change only just after posedge, so values seen here are those the next edge samples.
  always @(negedge clk) begin
    bit ez;
    ez = model_z();
    if (m_started) begin
      chk("z8", int'(z8), int'(ez));
      chk("z2", int'(z2), int'(ez));
      chk("z_reg8", int'(z_reg8), int'(m_zreg));
      chk("z_reg2", int'(z_reg2), int'(m_zreg));
      chk("cnt8", int'(cnt8), m_cnt8);
      chk("cnt2", int'(cnt2), m_cnt2);
    end
    if (!reset) begin
      m_q.delete();
      m_pat     = 4'b1101;
      m_zreg    = 1'b0;
      m_cnt8    = 0;
      m_cnt2    = 0;
      m_started = 1'b1;
    end else if (m_started) begin
      m_zreg = ez;
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (ez) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (pat_load) begin
        m_pat = pat_in;
        m_q.delete();
      end else if (en) begin
        if (ez && !overlap) m_q.delete();
        else begin
          m_q.push_back(p1);
          if (m_q.size() > 3) void'(m_q.pop_front());
        end
      end
    end
  end

  // One clock: drive inputs just after posedge, then sit at the following negedge.
  task automatic cyc(input logic r, input logic e, input logic b, input logic pl = 1'b0,
                     input logic [3:0] pi = 4'b0000, input logic cc = 1'b0);
    @(posedge clk);
    #1;
    reset = r; en = e; p1 = b; pat_load = pl; pat_in = pi; cnt_clr = cc;
    @(negedge clk);
  endtask

  task automatic stream(input string name, input int n, input logic [15:0] bits,
                        input logic [15:0] exp_z);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b1, 1'b1, bits[i]);
      chk(name, int'(z8), int'(exp_z[i]));
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    chk("reset_z", int'(z8), 0);
    chk("reset_z_reg", int'(z_reg8), 0);
    chk("reset_cnt", int'(cnt8), 0);

    // Overlapping detection of 1101 in 1101101.
    overlap = 1'b1;
    stream("ovl_z", 7, 16'b1101101, 16'b0001001);
    cyc(1'b1, 1'b0, 1'b0);
    chk("ovl_z_reg", int'(z_reg8), 1);
    chk("ovl_cnt", int'(cnt8), 2);

    // Non-overlapping: second match needs fresh bits.
    do_reset();
    overlap = 1'b0;
    stream("novl_z", 7, 16'b1101101, 16'b0001000);
    cyc(1'b1, 1'b0, 1'b0);
    chk("novl_cnt", int'(cnt8), 1);

    // Enable gaps hold the history and suppress z.
    do_reset();
    overlap = 1'b1;
    stream("gap_z", 2, 16'b11, 16'b00);
    cyc(1'b1, 1'b0, 1'b1); chk("gap_en0_z", int'(z8), 0);
    cyc(1'b1, 1'b0, 1'b0); chk("gap_en0_z", int'(z8), 0);
    cyc(1'b1, 1'b0, 1'b1); chk("gap_en0_z", int'(z8), 0);
    stream("gap_z", 2, 16'b01, 16'b01);
    cyc(1'b1, 1'b0, 1'b0);
    chk("gap_cnt", int'(cnt8), 1);

    // Pattern reload discards partial history and the concurrent bit.
    do_reset();
    overlap = 1'b0;
    stream("load_pre_z", 3, 16'b110, 16'b000);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    chk("load_cycle_z", int'(z8), 0);
    stream("load_new_z", 4, 16'b0110, 16'b0001);
    stream("load_old_z", 4, 16'b1101, 16'b0000);

    // Saturation on the 2-bit counter, then clear beating a coincident match.
    do_reset();
    overlap = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
    stream("sat_z", 8, 16'hFF, 16'b00011111);
    cyc(1'b1, 1'b0, 1'b0);
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_cnt8", int'(cnt8), 5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("clr_match_z", int'(z8), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("clr_cnt2", int'(cnt2), 0);
    chk("clr_cnt8", int'(cnt8), 0);
    chk("clr_z_reg", int'(z_reg8), 1);

    // Reset mid-stream drops partial history and restores the default pattern.
    do_reset();
    stream("rst_pre_z", 3, 16'b110, 16'b000);
    cyc(1'b0, 1'b1, 1'b1);
    chk("rst_cycle_z", int'(z8), 0);
    stream("rst_post_z", 1, 16'b1, 16'b0);
    chk("rst_post_z_reg", int'(z_reg8), 0);
    chk("rst_post_cnt", int'(cnt8), 0);
    stream("rst_new_z", 4, 16'b1101, 16'b0001);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst_new_cnt", int'(cnt8), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
